// File: rtl/exec_pkg.sv
// Shared types for the execute-result stage: condition codes, ALU op encodings and the NZCV layout.
package exec_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ROR = 2'b11;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM-style condition check of a 4-bit code against {N,Z,C,V}.
module cond_eval
    import exec_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    nzcv_t f;

    always_comb begin
        f    = nzcv_t'(nzcv);
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = f.z;
            COND_NE: pass = !f.z;
            COND_CS: pass = f.c;
            COND_CC: pass = !f.c;
            COND_MI: pass = f.n;
            COND_PL: pass = !f.n;
            COND_VS: pass = f.v;
            COND_VC: pass = !f.v;
            COND_HI: pass = f.c && !f.z;
            COND_LS: pass = !f.c || f.z;
            COND_GE: pass = (f.n == f.v);
            COND_LT: pass = (f.n != f.v);
            COND_GT: pass = !f.z && (f.n == f.v);
            COND_LE: pass = f.z || (f.n != f.v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_flag_stage.sv
// Execute-result stage: registers ALU output, owns NZCV, squashes condition-failing beats.
// Optional EXEC_STATS_EN adds saturating executed/squashed counters.
module exec_flag_stage
    import exec_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_nzcv,
    input  logic [1:0]        alu_op,
    input  logic              set_flags,
    input  logic [3:0]        cond,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              flag_load,
    input  logic [3:0]        flag_load_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wr_en,
    output logic [3:0]        nzcv,
    output logic              carry_out
`ifdef EXEC_STATS_EN
    ,
    output logic [CNT_W-1:0]  exec_cnt,
    output logic [CNT_W-1:0]  squash_cnt
`endif
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [RD_W-1:0]   out_rd_q, out_rd_d;
    logic              out_wr_en_q, out_wr_en_d;
    nzcv_t             nzcv_q, nzcv_d;
    nzcv_t             alu_f;
    logic              pass;
    logic              accept;

    cond_eval u_cond_eval (
        .cond (cond),
        .nzcv (nzcv_q),
        .pass (pass)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_wr_en_d  = out_wr_en_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_rd_d     = rd_in;
            out_wr_en_d  = pass;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // AND leaves C and V alone; ROR produces a carry but leaves V alone.
    always_comb begin
        alu_f  = nzcv_t'(alu_nzcv);
        nzcv_d = nzcv_q;
        if (flag_load) begin
            nzcv_d = nzcv_t'(flag_load_val);
        end else if (accept && pass && set_flags) begin
            nzcv_d.n = alu_f.n;
            nzcv_d.z = alu_f.z;
            if (alu_op != ALU_AND) begin
                nzcv_d.c = alu_f.c;
            end
            if (alu_op == ALU_ADD || alu_op == ALU_SUB) begin
                nzcv_d.v = alu_f.v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_wr_en_q  <= 1'b0;
            nzcv_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_wr_en_q  <= out_wr_en_d;
            nzcv_q       <= nzcv_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_wr_en  = out_wr_en_q;
    assign nzcv       = nzcv_q;
    assign carry_out  = nzcv_q.c;

`ifdef EXEC_STATS_EN
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (accept) begin
            if (pass && exec_cnt_q != '1) begin
                exec_cnt_d = exec_cnt_q + 1'b1;
            end
            if (!pass && squash_cnt_q != '1) begin
                squash_cnt_d = squash_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign exec_cnt   = exec_cnt_q;
    assign squash_cnt = squash_cnt_q;
`else
    logic [CNT_W-1:0] unused_stats;
    assign unused_stats = '0;
`endif

endmodule

// File: tb/tb_exec_flag_stage.sv
// Directed bench for exec_flag_stage: hand-written handshake/flag sequences plus a cond x NZCV vector table.
module tb_exec_flag_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 4;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_nzcv;
    logic [1:0]        alu_op;
    logic              set_flags;
    logic [3:0]        cond;
    logic [RD_W-1:0]   rd_in;
    logic              flag_load;
    logic [3:0]        flag_load_val;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_wr_en;
    logic [3:0]        nzcv;
    logic              carry_out;
`ifdef EXEC_STATS_EN
    logic [CNT_W-1:0]  exec_cnt;
    logic [CNT_W-1:0]  squash_cnt;
`endif

    exec_flag_stage #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .alu_nzcv      (alu_nzcv),
        .alu_op        (alu_op),
        .set_flags     (set_flags),
        .cond          (cond),
        .rd_in         (rd_in),
        .flag_load     (flag_load),
        .flag_load_val (flag_load_val),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_wr_en     (out_wr_en),
        .nzcv          (nzcv),
        .carry_out     (carry_out)
`ifdef EXEC_STATS_EN
        ,
        .exec_cnt      (exec_cnt),
        .squash_cnt    (squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       exp_pass;
    } vec_t;

    vec_t        vecs [256];
    logic [15:0] pass_mask [16];
    int unsigned vectors;
    int unsigned miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        alu_result    = '0;
        alu_nzcv      = 4'b0000;
        alu_op        = 2'b00;
        set_flags     = 1'b0;
        cond          = 4'd14;
        rd_in         = '0;
        flag_load     = 1'b0;
        flag_load_val = 4'b0000;
        out_ready     = 1'b1;
    endtask

    task automatic beat(input logic [1:0] op, input logic sf, input logic [3:0] c,
                        input logic [3:0] an, input logic [31:0] res, input logic [3:0] rd);
        in_valid   = 1'b1;
        alu_op     = op;
        set_flags  = sf;
        cond       = c;
        alu_nzcv   = an;
        alu_result = res;
        rd_in      = rd;
    endtask

    initial begin
        int unsigned exp_exec;
        int unsigned exp_squash;
        vectors     = 0;
        miscompares = 0;

        // bit i of a mask = pass when {N,Z,C,V} == i
        pass_mask[0]  = 16'hF0F0; pass_mask[1]  = 16'h0F0F;
        pass_mask[2]  = 16'hCCCC; pass_mask[3]  = 16'h3333;
        pass_mask[4]  = 16'hFF00; pass_mask[5]  = 16'h00FF;
        pass_mask[6]  = 16'hAAAA; pass_mask[7]  = 16'h5555;
        pass_mask[8]  = 16'h0C0C; pass_mask[9]  = 16'hF3F3;
        pass_mask[10] = 16'hAA55; pass_mask[11] = 16'h55AA;
        pass_mask[12] = 16'h0A05; pass_mask[13] = 16'hF5FA;
        pass_mask[14] = 16'hFFFF; pass_mask[15] = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                vecs[c*16+f].cond     = 4'(c);
                vecs[c*16+f].flags    = 4'(f);
                vecs[c*16+f].exp_pass = pass_mask[c][f];
            end
        end

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_wr_en", 32'(out_wr_en), 32'd0);
        check("rst_nzcv", 32'(nzcv), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #10;
        rst_n = 1'b1;
        tick();

        // 1: ADD setting Z under AL
        beat(2'b00, 1'b1, 4'd14, 4'b0100, 32'h0, 4'd3);
        tick();
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_wr_en", 32'(out_wr_en), 32'd1);
        check("t1_rd", 32'(out_rd), 32'd3);
        check("t1_nzcv", 32'(nzcv), 32'h4);

        // 2: NE squashed on Z=1, then EQ passes
        beat(2'b01, 1'b1, 4'd1, 4'b1111, 32'h11, 4'd4);
        tick();
        check("t2_ne_valid", 32'(out_valid), 32'd1);
        check("t2_ne_wr_en", 32'(out_wr_en), 32'd0);
        check("t2_ne_nzcv", 32'(nzcv), 32'h4);
        beat(2'b00, 1'b0, 4'd0, 4'b0000, 32'h22, 4'd5);
        tick();
        check("t2_eq_wr_en", 32'(out_wr_en), 32'd1);
        check("t2_eq_result", out_result, 32'h22);

        // 3: AND keeps C,V; ROR keeps V
        idle_inputs();
        flag_load     = 1'b1;
        flag_load_val = 4'b0011;
        tick();
        flag_load = 1'b0;
        check("t3_load_nzcv", 32'(nzcv), 32'h3);
        check("t3_drained", 32'(out_valid), 32'd0);
        beat(2'b10, 1'b1, 4'd14, 4'b1000, 32'h33, 4'd1);
        tick();
        check("t3_and_nzcv", 32'(nzcv), 32'hB);
        beat(2'b11, 1'b1, 4'd14, 4'b0110, 32'h44, 4'd2);
        tick();
        check("t3_ror_nzcv", 32'(nzcv), 32'h7);

        // back-to-back setters: second beat sees flags from the first
        beat(2'b01, 1'b1, 4'd0, 4'b0000, 32'h55, 4'd3);
        tick();
        check("b2b_first_wr_en", 32'(out_wr_en), 32'd1);
        check("b2b_first_nzcv", 32'(nzcv), 32'h0);
        beat(2'b00, 1'b0, 4'd0, 4'b0000, 32'h66, 4'd4);
        tick();
        check("b2b_second_wr_en", 32'(out_wr_en), 32'd0);

        // 4: backpressure holds output and ignores the waiting beat
        beat(2'b00, 1'b0, 4'd14, 4'b0000, 32'hA1, 4'd5);
        tick();
        out_ready = 1'b0;
        beat(2'b00, 1'b1, 4'd14, 4'b1111, 32'hB2, 4'd6);
        #1;
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_result", out_result, 32'hA1);
            check("t4_hold_rd", 32'(out_rd), 32'd5);
            check("t4_hold_nzcv", 32'(nzcv), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("t4_in_ready_high", 32'(in_ready), 32'd1);
        tick();
        check("t4_second_result", out_result, 32'hB2);
        check("t4_second_rd", 32'(out_rd), 32'd6);
        check("t4_second_nzcv", 32'(nzcv), 32'hF);
        idle_inputs();
        tick();
        check("t4_drain_valid", 32'(out_valid), 32'd0);

        // 5: flag_load beats a flag-setting SUB in the same cycle
        flag_load     = 1'b1;
        flag_load_val = 4'b0000;
        tick();
        flag_load_val = 4'b1111;
        beat(2'b01, 1'b1, 4'd14, 4'b0000, 32'h77, 4'd7);
        tick();
        check("t5_nzcv", 32'(nzcv), 32'hF);
        check("t5_carry", 32'(carry_out), 32'd1);
        check("t5_wr_en", 32'(out_wr_en), 32'd1);

        // reset mid-transfer drops the pending beat and clears flags
        idle_inputs();
        out_ready = 1'b0;
        beat(2'b00, 1'b0, 4'd14, 4'b0000, 32'h88, 4'd8);
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_nzcv", 32'(nzcv), 32'h0);
        check("mid_rst_carry", 32'(carry_out), 32'd0);
        idle_inputs();
        #4;
        rst_n = 1'b1;
        tick();

        // 6: all condition codes against all flag values
        exp_exec   = 0;
        exp_squash = 0;
        for (int i = 0; i < 256; i++) begin
            idle_inputs();
            flag_load     = 1'b1;
            flag_load_val = vecs[i].flags;
            tick();
            flag_load = 1'b0;
            beat(2'b00, 1'b0, vecs[i].cond, 4'b0000, 32'(i), 4'(i));
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_wr_en !== vecs[i].exp_pass) begin
                miscompares++;
                $display("FAIL cond_table cond=%0d nzcv=%b: got valid=%b wr_en=%b expected wr_en=%b",
                         vecs[i].cond, vecs[i].flags, out_valid, out_wr_en, vecs[i].exp_pass);
            end
            if (vecs[i].exp_pass) exp_exec++;
            else exp_squash++;
        end
        idle_inputs();
        tick();
`ifdef EXEC_STATS_EN
        check("stats_exec_cnt", 32'(exec_cnt), exp_exec);
        check("stats_squash_cnt", 32'(squash_cnt), exp_squash);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
